cmd_scheduler: RTL
==================

Name: cmd_scheduler

Overview:
- Consumes complete 4-byte command frames (cmd, arg1, arg2, crc) from the byte-collecting front end.
- Validates the frame CRC-8 and decodes the opcode.
- Sequences single-beat cartridge memory accesses through a req/ack handshake.
- Emits one response byte per accepted frame toward the serial return path.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles mem_req waits for mem_ack before aborting; 1..65535
- ACK_BYTE, 8'hA5, response byte for successful non-read commands

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- frame_valid  in  1  one-cycle pulse: cmd/arg1/arg2/crc hold a new complete frame
- cmd  in  8  opcode
- arg1  in  8  argument byte 1
- arg2  in  8  argument byte 2
- crc  in  8  CRC-8 of cmd,arg1,arg2
- mem_addr  out  16  memory address
- mem_wdata  out  8  write data
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
- mem_req  out  1  request, held until mem_ack
- mem_rdata  in  8  read data, sampled in the mem_ack cycle
- mem_ack  in  1  one-cycle completion pulse
- resp_byte  out  8  response byte
- resp_valid  out  1  response available, held until resp_ready
- resp_ready  in  1  consumer accepts resp_byte when resp_valid & resp_ready
- busy  out  1  1 whenever state != IDLE
- overrun  out  1  sticky: a frame arrived while busy

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE; addr_reg=16'h0000; all outputs 0 (mem_addr, mem_wdata, resp_byte = 0).
- The front end guarantees cmd/arg1/arg2/crc are stable in the frame_valid cycle only; latch all four on acceptance.
- IDLE: on frame_valid, latch the frame and go to CHECK.
- CHECK (1 cycle): CRC-8 is poly 0x07, init 0x00, MSB-first over cmd, arg1, arg2. Decode:
  - CRC mismatch -> resp=8'hE0, go to RESPOND.
  - 0x00 NOP -> resp=ACK_BYTE, go to RESPOND.
  - 0x03 SET_ADDR -> addr_reg={arg1,arg2}; resp=ACK_BYTE; go to RESPOND.
  - 0x01 READ -> mem_addr=addr_reg, mem_we=0, mem_req=1; go to MEM.
  - 0x02 WRITE -> mem_addr=addr_reg, mem_wdata=arg1, mem_we=1, mem_req=1; go to MEM.
  - Any other opcode -> resp=8'hE1, go to RESPOND.
- MEM: hold mem_req, mem_addr, mem_we, mem_wdata stable. Timeout counter starts at 0 on entry and increments each cycle.
  - On mem_ack: mem_req=0; addr_reg=addr_reg+1 (wraps 16'hFFFF->16'h0000); resp=mem_rdata for READ, ACK_BYTE for WRITE; go to RESPOND.
  - If the counter reaches TIMEOUT_CYCLES without ack: mem_req=0; addr_reg unchanged; resp=8'hE2; go to RESPOND.
  - mem_ack in the same cycle the counter reaches TIMEOUT_CYCLES counts as an ack, not a timeout.
  - mem_ack outside MEM is ignored.
- RESPOND: resp_valid=1 with resp_byte stable. On resp_ready: resp_valid=0 next cycle, go to IDLE.
- Latency: frame_valid at cycle N -> resp_valid=1 at cycle N+2 for non-memory commands. For memory commands, mem_req=1 at N+2 and resp_valid=1 the cycle after mem_ack.
- overrun:
  - Set when frame_valid arrives in any state other than IDLE; that frame is dropped.
  - Cleared when the next frame is accepted in IDLE.
  - If frame_valid is dropped in RESPOND during the handshake cycle, overrun is still set.
- busy=1 in every state except IDLE.
- Reset mid-operation: mem_req and resp_valid drop the next cycle; no pending response survives reset.

Optional Feature:
- Macro: CMD_SCHEDULER_CRC_CHECK_EN.
- Defined: CRC is checked as above; a mismatch produces 8'hE0.
- Undefined: no CRC logic is built; the crc input is ignored and every frame is decoded as if its CRC were correct.

Test Plan:
- NOP frame 00 00 00 00, resp_ready=1 -> resp_valid at frame_valid+2, resp_byte=8'hA5, busy low one cycle later.
- Frame 00 00 00 01 (CRC bad) -> resp_byte=8'hE0, no mem_req. With macro undefined -> 8'hA5.
- SET_ADDR 03 00 00 BD, then READ 01 00 00 6B with mem_ack after 3 cycles and mem_rdata=8'h5A:
  - mem_addr=16'h0000, mem_we=0 during the request.
  - resp_byte=8'h5A.
  - A second READ uses mem_addr=16'h0001.
- WRITE with mem_ack never asserted, TIMEOUT_CYCLES=4 -> mem_req drops after 4 cycles; resp_byte=8'hE2; next READ uses the same address.
- Unknown opcode with correct CRC -> resp_byte=8'hE1. Second frame_valid pulsed while resp_ready=0 -> frame dropped, overrun=1; next accepted frame clears it.
- Assert reset during MEM with mem_req=1 -> mem_req=0, resp_valid=0, addr_reg=16'h0000 next cycle.

Source files
------------

// File: rtl/cmd_scheduler.sv
// Command frame scheduler: CRC-8 check, opcode decode, req/ack memory sequencing and one response byte per frame.
// Define CMD_SCHEDULER_CRC_CHECK_EN to build the CRC check; without it the crc input is ignored.
module cmd_scheduler #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [7:0]  ACK_BYTE       = 8'hA5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_valid,
   input  logic [7:0]  cmd,
   input  logic [7:0]  arg1,
   input  logic [7:0]  arg2,
   input  logic [7:0]  crc,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_we,
   output logic        mem_req,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ack,
   output logic [7:0]  resp_byte,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic        busy,
   output logic        overrun
);

   typedef enum logic [1:0] {IDLE, CHECK, MEM, RESPOND} state_t;

   localparam logic [7:0]  OP_NOP       = 8'h00;
   localparam logic [7:0]  OP_READ      = 8'h01;
   localparam logic [7:0]  OP_WRITE     = 8'h02;
   localparam logic [7:0]  OP_SET_ADDR  = 8'h03;
   localparam logic [7:0]  RESP_CRC_ERR = 8'hE0;
   localparam logic [7:0]  RESP_BAD_OP  = 8'hE1;
   localparam logic [7:0]  RESP_TIMEOUT = 8'hE2;
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_q;
   logic [7:0]  cmd_q;
   logic [7:0]  arg1_q;
   logic [7:0]  arg2_q;
   logic [15:0] addrReg_q;
   logic [15:0] timeoutCnt_q;
   logic [15:0] memAddr_q;
   logic [7:0]  memWdata_q;
   logic        memWe_q;
   logic        memReq_q;
   logic [7:0]  respByte_q;
   logic        respValid_q;
   logic        overrun_q;
   logic        crcOk;

`ifdef CMD_SCHEDULER_CRC_CHECK_EN
   logic [7:0] crc_q;

   function automatic logic [7:0] crc8Update(input logic [7:0] crcIn, input logic [7:0] data);
      logic [7:0] c;
      c = crcIn ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
      end
      return c;
   endfunction

   assign crcOk = (crc8Update(crc8Update(crc8Update(8'h00, cmd_q), arg1_q), arg2_q) == crc_q);
`else
   logic unusedCrc;
   assign unusedCrc = ^crc;
   assign crcOk     = 1'b1;
`endif

   // The frame bytes are only valid during frame_valid, so everything the later states need is latched in IDLE.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         cmd_q        <= '0;
         arg1_q       <= '0;
         arg2_q       <= '0;
         addrReg_q    <= '0;
         timeoutCnt_q <= '0;
         memAddr_q    <= '0;
         memWdata_q   <= '0;
         memWe_q      <= 1'b0;
         memReq_q     <= 1'b0;
         respByte_q   <= '0;
         respValid_q  <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef CMD_SCHEDULER_CRC_CHECK_EN
         crc_q        <= '0;
`endif
      end else begin
         if (frame_valid && state_q != IDLE) begin
            overrun_q <= 1'b1;
         end
         unique case (state_q)
            IDLE: begin
               if (frame_valid) begin
                  cmd_q     <= cmd;
                  arg1_q    <= arg1;
                  arg2_q    <= arg2;
`ifdef CMD_SCHEDULER_CRC_CHECK_EN
                  crc_q     <= crc;
`endif
                  overrun_q <= 1'b0;
                  state_q   <= CHECK;
               end
            end
            CHECK: begin
               timeoutCnt_q <= '0;
               if (!crcOk) begin
                  respByte_q  <= RESP_CRC_ERR;
                  respValid_q <= 1'b1;
                  state_q     <= RESPOND;
               end else begin
                  case (cmd_q)
                     OP_NOP: begin
                        respByte_q  <= ACK_BYTE;
                        respValid_q <= 1'b1;
                        state_q     <= RESPOND;
                     end
                     OP_SET_ADDR: begin
                        addrReg_q   <= {arg1_q, arg2_q};
                        respByte_q  <= ACK_BYTE;
                        respValid_q <= 1'b1;
                        state_q     <= RESPOND;
                     end
                     OP_READ: begin
                        memAddr_q <= addrReg_q;
                        memWe_q   <= 1'b0;
                        memReq_q  <= 1'b1;
                        state_q   <= MEM;
                     end
                     OP_WRITE: begin
                        memAddr_q  <= addrReg_q;
                        memWdata_q <= arg1_q;
                        memWe_q    <= 1'b1;
                        memReq_q   <= 1'b1;
                        state_q    <= MEM;
                     end
                     default: begin
                        respByte_q  <= RESP_BAD_OP;
                        respValid_q <= 1'b1;
                        state_q     <= RESPOND;
                     end
                  endcase
               end
            end
            // An ack arriving in the last allowed cycle wins over the timeout.
            MEM: begin
               if (mem_ack) begin
                  memReq_q    <= 1'b0;
                  addrReg_q   <= addrReg_q + 16'd1;
                  respByte_q  <= memWe_q ? ACK_BYTE : mem_rdata;
                  respValid_q <= 1'b1;
                  state_q     <= RESPOND;
               end else if (timeoutCnt_q == TIMEOUT_LAST) begin
                  memReq_q    <= 1'b0;
                  respByte_q  <= RESP_TIMEOUT;
                  respValid_q <= 1'b1;
                  state_q     <= RESPOND;
               end else begin
                  timeoutCnt_q <= timeoutCnt_q + 16'd1;
               end
            end
            RESPOND: begin
               if (resp_ready) begin
                  respValid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
         endcase
      end
   end

   assign mem_addr   = memAddr_q;
   assign mem_wdata  = memWdata_q;
   assign mem_we     = memWe_q;
   assign mem_req    = memReq_q;
   assign resp_byte  = respByte_q;
   assign resp_valid = respValid_q;
   assign busy       = (state_q != IDLE);
   assign overrun    = overrun_q;

endmodule
